// File: rtl/cpu_pkg.sv
// Shared Mini SRC control definitions: opcodes, sequencer steps, instruction classes
// and the strobe bundle driven by control_unit.
package cpu_pkg;

  localparam int OPC_W    = 5;
  localparam int LINK_REG = 15;

  typedef logic [OPC_W-1:0] opcode_t;

  localparam opcode_t OP_LD   = 5'b00000;
  localparam opcode_t OP_LDI  = 5'b00001;
  localparam opcode_t OP_ST   = 5'b00010;
  localparam opcode_t OP_ADD  = 5'b00011;
  localparam opcode_t OP_SUB  = 5'b00100;
  localparam opcode_t OP_AND  = 5'b00101;
  localparam opcode_t OP_OR   = 5'b00110;
  localparam opcode_t OP_SHR  = 5'b00111;
  localparam opcode_t OP_SHRA = 5'b01000;
  localparam opcode_t OP_SHL  = 5'b01001;
  localparam opcode_t OP_ROR  = 5'b01010;
  localparam opcode_t OP_ROL  = 5'b01011;
  localparam opcode_t OP_ADDI = 5'b01100;
  localparam opcode_t OP_ANDI = 5'b01101;
  localparam opcode_t OP_ORI  = 5'b01110;
  localparam opcode_t OP_MUL  = 5'b01111;
  localparam opcode_t OP_DIV  = 5'b10000;
  localparam opcode_t OP_NEG  = 5'b10001;
  localparam opcode_t OP_NOT  = 5'b10010;
  localparam opcode_t OP_BR   = 5'b10011;
  localparam opcode_t OP_JR   = 5'b10100;
  localparam opcode_t OP_JAL  = 5'b10101;
  localparam opcode_t OP_IN   = 5'b10110;
  localparam opcode_t OP_OUT  = 5'b10111;
  localparam opcode_t OP_MFHI = 5'b11000;
  localparam opcode_t OP_MFLO = 5'b11001;
  localparam opcode_t OP_NOP  = 5'b11010;
  localparam opcode_t OP_HALT = 5'b11011;

  // T0..T7 must stay consecutive: the sequencer advances by incrementing the step.
  typedef enum logic [3:0] {
    S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } step_t;

  typedef enum logic [4:0] {
    CL_ALU_R, CL_ALU_I, CL_LDI, CL_LD, CL_ST, CL_MULDIV, CL_UNARY, CL_BR, CL_JR,
    CL_JAL, CL_IN, CL_OUT, CL_MFHI, CL_MFLO, CL_NOP, CL_HALT, CL_ILL
  } iclass_t;

  typedef struct packed {
    logic pc_out, mdr_out, zhigh_out, zlow_out, hi_out, lo_out, inport_out, c_out, ba_out, r_out;
    logic r_in, gra, grb, grc, mar_en, mdr_en, mdr_read, ir_en, y_en;
    logic zhigh_in, zlow_in, hi_en, lo_en, pc_en, con_en, outport_en, inc_pc, ram_write;
    logic link_sel;
  } ctrl_t;

  function automatic step_t last_step(input iclass_t c);
    case (c)
      CL_ALU_R, CL_ALU_I, CL_LDI:             return S_T5;
      CL_LD, CL_ST:                           return S_T7;
      CL_MULDIV, CL_BR:                       return S_T6;
      CL_UNARY, CL_JAL:                       return S_T4;
      CL_JR, CL_IN, CL_OUT, CL_MFHI, CL_MFLO: return S_T3;
      default:                                return S_T2;
    endcase
  endfunction

  function automatic opcode_t imm_alu_op(input opcode_t opc);
    case (opc)
      OP_ADDI: return OP_ADD;
      OP_ANDI: return OP_AND;
      default: return OP_OR;
    endcase
  endfunction

endpackage

// File: rtl/instr_class_dec.sv
// Maps an opcode onto the instruction class that selects its execute sequence.
module instr_class_dec
  import cpu_pkg::*;
(
  input  opcode_t opcode,
  output iclass_t iclass
);

  always_comb begin
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL:
                             iclass = CL_ALU_R;
      OP_ADDI, OP_ANDI, OP_ORI: iclass = CL_ALU_I;
      OP_LDI:                iclass = CL_LDI;
      OP_LD:                 iclass = CL_LD;
      OP_ST:                 iclass = CL_ST;
      OP_MUL, OP_DIV:        iclass = CL_MULDIV;
      OP_NEG, OP_NOT:        iclass = CL_UNARY;
      OP_BR:                 iclass = CL_BR;
      OP_JR:                 iclass = CL_JR;
      OP_JAL:                iclass = CL_JAL;
      OP_IN:                 iclass = CL_IN;
      OP_OUT:                iclass = CL_OUT;
      OP_MFHI:               iclass = CL_MFHI;
      OP_MFLO:               iclass = CL_MFLO;
      OP_NOP:                iclass = CL_NOP;
      OP_HALT:               iclass = CL_HALT;
      default:               iclass = CL_ILL;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired Moore sequencer for the Mini SRC datapath: fetch T0-T2, per-class
// execute steps T3-T7, halt on the halt opcode or a pending stop request.
module control_unit
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] ir,
  input  logic        con_ff,
  input  logic        stop,
  output logic PCout, MDRout, ZHighout, ZLowout, HIout, LOout, InPortout, Cout, BAout, Rout,
  output logic Rin, Gra, Grb, Grc, MAR_enable, MDR_enable, MDR_read, IR_enable, Y_enable,
  output logic ZHighIn, ZLowIn, HI_enable, LO_enable, PC_enable, CON_enable, OutPort_enable,
  output logic IncPC, RAM_write,
  output logic [OPC_W-1:0] alu_op,
  output logic        link_sel,
  output logic        run,
  output logic        illegal
);

  step_t   state_q, state_d;
  opcode_t opc_q, opc_dec, alu;
  iclass_t iclass;
  ctrl_t   ctl;
  logic    illegal_q, stop_pend_q, halt_req;

  // Only the opcode field of ir matters here.
  logic unused_ir_bits;
  assign unused_ir_bits = ^ir[26:0];

  // During T2 the opcode is still on ir; it is captured at the end of T2, so
  // the branch out of fetch has to look at the live value.
  assign opc_dec  = (state_q == S_T2) ? ir[31:27] : opc_q;
  assign halt_req = stop | stop_pend_q;

  instr_class_dec u_dec (
    .opcode (opc_dec),
    .iclass (iclass)
  );

  // NOTE: sequential state uses non-blocking assignment so every register sees pre-edge values.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q     <= S_RST;
      opc_q       <= '0;
      illegal_q   <= 1'b0;
      stop_pend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_T2) begin
        opc_q <= ir[31:27];
        if (iclass == CL_ILL) illegal_q <= 1'b1;
      end
      if (state_q == S_RST || state_q == S_HALT) stop_pend_q <= 1'b0;
      else if (stop)                             stop_pend_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RST:  state_d = S_T0;
      S_T0:   state_d = S_T1;
      S_T1:   state_d = S_T2;
      S_HALT: state_d = S_HALT;
      default: begin
        if (state_q == S_T2 && iclass == CL_HALT) state_d = S_HALT;
        else if (state_q == last_step(iclass))   state_d = halt_req ? S_HALT : S_T0;
        else                                     state_d = step_t'(state_q + 4'd1);
      end
    endcase
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    ctl = '0;
    alu = '0;
    case (state_q)
      S_T0: begin
        ctl.pc_out = 1'b1; ctl.mar_en = 1'b1; ctl.inc_pc = 1'b1; ctl.zlow_in = 1'b1;
        alu = OP_ADD;
      end
      S_T1: begin
        ctl.zlow_out = 1'b1; ctl.pc_en = 1'b1; ctl.mdr_read = 1'b1; ctl.mdr_en = 1'b1;
      end
      S_T2: begin
        ctl.mdr_out = 1'b1; ctl.ir_en = 1'b1;
      end
      S_T3, S_T4, S_T5, S_T6, S_T7: begin
        alu = opc_q;
        case (iclass)
          CL_ALU_R, CL_ALU_I: begin
            if (iclass == CL_ALU_I) alu = imm_alu_op(opc_q);
            case (state_q)
              S_T3: begin ctl.grb = 1'b1; ctl.r_out = 1'b1; ctl.y_en = 1'b1; end
              S_T4: begin
                ctl.zlow_in = 1'b1;
                if (iclass == CL_ALU_I) ctl.c_out = 1'b1;
                else begin ctl.grc = 1'b1; ctl.r_out = 1'b1; end
              end
              S_T5: begin ctl.zlow_out = 1'b1; ctl.gra = 1'b1; ctl.r_in = 1'b1; end
              default: ;
            endcase
          end
          // ldi, ld and st share the effective-address computation in T3-T4.
          CL_LDI, CL_LD, CL_ST: begin
            case (state_q)
              S_T3: begin ctl.grb = 1'b1; ctl.ba_out = 1'b1; ctl.y_en = 1'b1; end
              S_T4: begin ctl.c_out = 1'b1; ctl.zlow_in = 1'b1; alu = OP_ADD; end
              S_T5: begin
                ctl.zlow_out = 1'b1;
                if (iclass == CL_LDI) begin ctl.gra = 1'b1; ctl.r_in = 1'b1; end
                else                  ctl.mar_en = 1'b1;
              end
              S_T6: begin
                ctl.mdr_en = 1'b1;
                if (iclass == CL_LD) ctl.mdr_read = 1'b1;
                else begin ctl.gra = 1'b1; ctl.r_out = 1'b1; end
              end
              S_T7: begin
                if (iclass == CL_LD) begin ctl.mdr_out = 1'b1; ctl.gra = 1'b1; ctl.r_in = 1'b1; end
                else                 ctl.ram_write = 1'b1;
              end
              default: ;
            endcase
          end
          CL_MULDIV: begin
            case (state_q)
              S_T3: begin ctl.gra = 1'b1; ctl.r_out = 1'b1; ctl.y_en = 1'b1; end
              S_T4: begin ctl.grb = 1'b1; ctl.r_out = 1'b1; ctl.zhigh_in = 1'b1; ctl.zlow_in = 1'b1; end
              S_T5: begin ctl.zlow_out = 1'b1; ctl.lo_en = 1'b1; end
              S_T6: begin ctl.zhigh_out = 1'b1; ctl.hi_en = 1'b1; end
              default: ;
            endcase
          end
          CL_UNARY: begin
            case (state_q)
              S_T3: begin ctl.grb = 1'b1; ctl.r_out = 1'b1; ctl.zlow_in = 1'b1; end
              S_T4: begin ctl.zlow_out = 1'b1; ctl.gra = 1'b1; ctl.r_in = 1'b1; end
              default: ;
            endcase
          end
          CL_BR: begin
            case (state_q)
              S_T3: begin ctl.gra = 1'b1; ctl.r_out = 1'b1; ctl.con_en = 1'b1; end
              S_T4: begin ctl.pc_out = 1'b1; ctl.y_en = 1'b1; end
              S_T5: begin ctl.c_out = 1'b1; ctl.zlow_in = 1'b1; alu = OP_ADD; end
              S_T6: begin
                ctl.zlow_out = con_ff;
                ctl.pc_en    = con_ff;
              end
              default: ;
            endcase
          end
          CL_JR:
            if (state_q == S_T3) begin ctl.gra = 1'b1; ctl.r_out = 1'b1; ctl.pc_en = 1'b1; end
          CL_JAL: begin
            case (state_q)
              S_T3: begin ctl.pc_out = 1'b1; ctl.link_sel = 1'b1; ctl.r_in = 1'b1; end
              S_T4: begin ctl.gra = 1'b1; ctl.r_out = 1'b1; ctl.pc_en = 1'b1; end
              default: ;
            endcase
          end
          CL_IN:
            if (state_q == S_T3) begin ctl.inport_out = 1'b1; ctl.gra = 1'b1; ctl.r_in = 1'b1; end
          CL_OUT:
            if (state_q == S_T3) begin ctl.gra = 1'b1; ctl.r_out = 1'b1; ctl.outport_en = 1'b1; end
          CL_MFHI:
            if (state_q == S_T3) begin ctl.hi_out = 1'b1; ctl.gra = 1'b1; ctl.r_in = 1'b1; end
          CL_MFLO:
            if (state_q == S_T3) begin ctl.lo_out = 1'b1; ctl.gra = 1'b1; ctl.r_in = 1'b1; end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign PCout          = ctl.pc_out;
  assign MDRout         = ctl.mdr_out;
  assign ZHighout       = ctl.zhigh_out;
  assign ZLowout        = ctl.zlow_out;
  assign HIout          = ctl.hi_out;
  assign LOout          = ctl.lo_out;
  assign InPortout      = ctl.inport_out;
  assign Cout           = ctl.c_out;
  assign BAout          = ctl.ba_out;
  assign Rout           = ctl.r_out;
  assign Rin            = ctl.r_in;
  assign Gra            = ctl.gra;
  assign Grb            = ctl.grb;
  assign Grc            = ctl.grc;
  assign MAR_enable     = ctl.mar_en;
  assign MDR_enable     = ctl.mdr_en;
  assign MDR_read       = ctl.mdr_read;
  assign IR_enable      = ctl.ir_en;
  assign Y_enable       = ctl.y_en;
  assign ZHighIn        = ctl.zhigh_in;
  assign ZLowIn         = ctl.zlow_in;
  assign HI_enable      = ctl.hi_en;
  assign LO_enable      = ctl.lo_en;
  assign PC_enable      = ctl.pc_en;
  assign CON_enable     = ctl.con_en;
  assign OutPort_enable = ctl.outport_en;
  assign IncPC          = ctl.inc_pc;
  assign RAM_write      = ctl.ram_write;
  assign link_sel       = ctl.link_sel;
  assign alu_op         = alu;
  assign run            = (state_q != S_RST) && (state_q != S_HALT);
  assign illegal        = illegal_q;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed vector table, hand-written
// reset/stop/halt sequences, then random instruction streams against a sequence model.
module tb_control_unit;

  logic clk = 1'b0;
  logic clr, con_ff, stop;
  logic [31:0] ir;
  logic PCout, MDRout, ZHighout, ZLowout, HIout, LOout, InPortout, Cout, BAout, Rout;
  logic Rin, Gra, Grb, Grc, MAR_enable, MDR_enable, MDR_read, IR_enable, Y_enable;
  logic ZHighIn, ZLowIn, HI_enable, LO_enable, PC_enable, CON_enable, OutPort_enable;
  logic IncPC, RAM_write, link_sel, run, illegal;
  logic [4:0] alu_op;

  always #5 clk = ~clk;

  control_unit dut (
    .clk(clk), .clr(clr), .ir(ir), .con_ff(con_ff), .stop(stop),
    .PCout(PCout), .MDRout(MDRout), .ZHighout(ZHighout), .ZLowout(ZLowout), .HIout(HIout),
    .LOout(LOout), .InPortout(InPortout), .Cout(Cout), .BAout(BAout), .Rout(Rout),
    .Rin(Rin), .Gra(Gra), .Grb(Grb), .Grc(Grc), .MAR_enable(MAR_enable), .MDR_enable(MDR_enable),
    .MDR_read(MDR_read), .IR_enable(IR_enable), .Y_enable(Y_enable), .ZHighIn(ZHighIn),
    .ZLowIn(ZLowIn), .HI_enable(HI_enable), .LO_enable(LO_enable), .PC_enable(PC_enable),
    .CON_enable(CON_enable), .OutPort_enable(OutPort_enable), .IncPC(IncPC), .RAM_write(RAM_write),
    .alu_op(alu_op), .link_sel(link_sel), .run(run), .illegal(illegal)
  );

  // Strobe bit positions in the bench's own observation word.
  localparam logic [28:0] PCO = 29'h1 << 0,  MDRO = 29'h1 << 1,  ZHO  = 29'h1 << 2,  ZLO  = 29'h1 << 3;
  localparam logic [28:0] HIO = 29'h1 << 4,  LOO  = 29'h1 << 5,  INO  = 29'h1 << 6,  CO   = 29'h1 << 7;
  localparam logic [28:0] BAO = 29'h1 << 8,  RO   = 29'h1 << 9,  RIN  = 29'h1 << 10, GRA  = 29'h1 << 11;
  localparam logic [28:0] GRB = 29'h1 << 12, GRC  = 29'h1 << 13, MARE = 29'h1 << 14, MDRE = 29'h1 << 15;
  localparam logic [28:0] MDRR = 29'h1 << 16, IRE = 29'h1 << 17, YE   = 29'h1 << 18, ZHI  = 29'h1 << 19;
  localparam logic [28:0] ZLI = 29'h1 << 20, HIE  = 29'h1 << 21, LOE  = 29'h1 << 22, PCE  = 29'h1 << 23;
  localparam logic [28:0] CONE = 29'h1 << 24, OUTE = 29'h1 << 25, INCPC = 29'h1 << 26, RAMW = 29'h1 << 27;
  localparam logic [28:0] LINK = 29'h1 << 28;
  localparam logic [4:0]  A_ADD = 5'd3, A_AND = 5'd5, A_OR = 5'd6;
  localparam logic [28:0] FETCH0 = PCO | MARE | INCPC | ZLI;

  typedef struct packed {
    logic [28:0] s;
    logic [4:0]  alu;
    logic        run;
    logic        ill;
  } obs_t;

  typedef struct {
    string       name;
    logic [31:0] word;
    bit          con;
    int          step;
    logic [28:0] mask;
    logic [4:0]  alu;
    int          ncyc;
  } vec_t;

  int n_checks = 0;
  int n_errors = 0;
  logic [28:0] m_seq[$];
  logic [4:0]  m_alu[$];
  bit m_illegal, m_halted;

  function automatic obs_t observe();
    obs_t o;
    o.s = {link_sel, RAM_write, IncPC, OutPort_enable, CON_enable, PC_enable, LO_enable, HI_enable,
           ZLowIn, ZHighIn, Y_enable, IR_enable, MDR_read, MDR_enable, MAR_enable, Grc, Grb, Gra,
           Rin, Rout, BAout, Cout, InPortout, LOout, HIout, ZLowout, ZHighout, MDRout, PCout};
    o.alu = alu_op;
    o.run = run;
    o.ill = illegal;
    return o;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic seq(input logic [28:0] s, input logic [4:0] a);
    m_seq.push_back(s);
    m_alu.push_back(a);
  endtask

  // Execute-phase microprogram of one instruction, step by step after fetch.
  task automatic model_exec(input logic [4:0] opc, input bit con);
    m_seq.delete();
    m_alu.delete();
    case (opc)
      5'd0: begin  // ld
        seq(GRB|BAO|YE, opc); seq(CO|ZLI, A_ADD); seq(ZLO|MARE, opc);
        seq(MDRR|MDRE, opc); seq(MDRO|GRA|RIN, opc);
      end
      5'd1: begin seq(GRB|BAO|YE, opc); seq(CO|ZLI, A_ADD); seq(ZLO|GRA|RIN, opc); end
      5'd2: begin  // st
        seq(GRB|BAO|YE, opc); seq(CO|ZLI, A_ADD); seq(ZLO|MARE, opc);
        seq(GRA|RO|MDRE, opc); seq(RAMW, opc);
      end
      5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11: begin
        seq(GRB|RO|YE, opc); seq(GRC|RO|ZLI, opc); seq(ZLO|GRA|RIN, opc);
      end
      5'd12, 5'd13, 5'd14: begin
        logic [4:0] a;
        a = (opc == 5'd12) ? A_ADD : (opc == 5'd13) ? A_AND : A_OR;
        seq(GRB|RO|YE, a); seq(CO|ZLI, a); seq(ZLO|GRA|RIN, a);
      end
      5'd15, 5'd16: begin
        seq(GRA|RO|YE, opc); seq(GRB|RO|ZHI|ZLI, opc); seq(ZLO|LOE, opc); seq(ZHO|HIE, opc);
      end
      5'd17, 5'd18: begin seq(GRB|RO|ZLI, opc); seq(ZLO|GRA|RIN, opc); end
      5'd19: begin
        seq(GRA|RO|CONE, opc); seq(PCO|YE, opc); seq(CO|ZLI, A_ADD);
        seq(con ? (ZLO|PCE) : 29'h0, opc);
      end
      5'd20: seq(GRA|RO|PCE, opc);
      5'd21: begin seq(PCO|LINK|RIN, opc); seq(GRA|RO|PCE, opc); end
      5'd22: seq(INO|GRA|RIN, opc);
      5'd23: seq(GRA|RO|OUTE, opc);
      5'd24: seq(HIO|GRA|RIN, opc);
      5'd25: seq(LOO|GRA|RIN, opc);
      default: ;  // nop, halt and undefined codes have no execute steps
    endcase
  endtask

  task automatic do_reset();
    clr  = 1'b0;
    stop = 1'b0;
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    m_illegal = 1'b0;
    m_halted  = 1'b0;
  endtask

  // Runs one instruction from its T0 against the model, one comparison per step.
  task automatic run_model_instr(input string tag, input logic [31:0] word, input bit con,
                                 input int stop_idx);
    logic [4:0] opc;
    obs_t e;
    int n;
    opc = word[31:27];
    model_exec(opc, con);
    n = 3 + m_seq.size();
    ir = word;
    con_ff = con;
    for (int k = 0; k < n; k++) begin
      e.run = 1'b1;
      e.ill = (k < 3) ? m_illegal : (m_illegal | (opc >= 5'd28));
      case (k)
        0:       begin e.s = FETCH0;           e.alu = A_ADD; end
        1:       begin e.s = ZLO|PCE|MDRR|MDRE; e.alu = 5'd0;  end
        2:       begin e.s = MDRO|IRE;          e.alu = 5'd0;  end
        default: begin e.s = m_seq[k-3];        e.alu = m_alu[k-3]; end
      endcase
      check($sformatf("%s.op%0d.k%0d", tag, opc, k), 64'(observe()), 64'(e));
      stop = (k == stop_idx);
      if (k == 3) ir = $urandom;
      @(negedge clk);
    end
    stop = 1'b0;
    if (opc >= 5'd28) m_illegal = 1'b1;
    if (opc == 5'd27 || stop_idx >= 0) m_halted = 1'b1;
  endtask

  task automatic check_halted(input string tag, input int cycles);
    obs_t e;
    e = '{s: 29'h0, alu: 5'd0, run: 1'b0, ill: m_illegal};
    for (int k = 0; k < cycles; k++) begin
      check($sformatf("%s.halt%0d", tag, k), 64'(observe()), 64'(e));
      ir = $urandom;
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vec[20];
    int cyc;
    bit done;
    logic [4:0] opc;
    int stop_idx;

    vec[0]  = '{"add.T3",  32'h18908000, 1'b0, 3, GRB|RO|YE,       5'd3,  6};
    vec[1]  = '{"add.T4",  32'h18908000, 1'b0, 4, GRC|RO|ZLI,      5'd3,  6};
    vec[2]  = '{"add.T5",  32'h18908000, 1'b0, 5, ZLO|GRA|RIN,     5'd3,  6};
    vec[3]  = '{"ld.T5",   32'h00800055, 1'b0, 5, ZLO|MARE,        5'd0,  8};
    vec[4]  = '{"ld.T6",   32'h00800055, 1'b0, 6, MDRR|MDRE,       5'd0,  8};
    vec[5]  = '{"ld.T7",   32'h00800055, 1'b0, 7, MDRO|GRA|RIN,    5'd0,  8};
    vec[6]  = '{"br0.T6",  32'h98000000, 1'b0, 6, 29'h0,           5'd19, 7};
    vec[7]  = '{"br1.T6",  32'h98000000, 1'b1, 6, ZLO|PCE,         5'd19, 7};
    vec[8]  = '{"mul.T4",  32'h78880000, 1'b0, 4, GRB|RO|ZHI|ZLI,  5'd15, 7};
    vec[9]  = '{"mul.T5",  32'h78880000, 1'b0, 5, ZLO|LOE,         5'd15, 7};
    vec[10] = '{"mul.T6",  32'h78880000, 1'b0, 6, ZHO|HIE,         5'd15, 7};
    vec[11] = '{"addi.T4", 32'h60000000, 1'b0, 4, CO|ZLI,          A_ADD, 6};
    vec[12] = '{"andi.T3", 32'h68000000, 1'b0, 3, GRB|RO|YE,       A_AND, 6};
    vec[13] = '{"st.T6",   32'h10000000, 1'b0, 6, GRA|RO|MDRE,     5'd2,  8};
    vec[14] = '{"st.T7",   32'h10000000, 1'b0, 7, RAMW,            5'd2,  8};
    vec[15] = '{"jal.T3",  32'hA8000000, 1'b0, 3, PCO|LINK|RIN,    5'd21, 5};
    vec[16] = '{"nop.T2",  32'hD0000000, 1'b0, 2, MDRO|IRE,        5'd0,  3};
    vec[17] = '{"neg.T4",  32'h88000000, 1'b0, 4, ZLO|GRA|RIN,     5'd17, 5};
    vec[18] = '{"in.T3",   32'hB0000000, 1'b0, 3, INO|GRA|RIN,     5'd22, 4};
    vec[19] = '{"ldi.T4",  32'h08000000, 1'b0, 4, CO|ZLI,          A_ADD, 6};

    clr = 1'b0; stop = 1'b0; con_ff = 1'b0; ir = 32'h0;
    m_illegal = 1'b0; m_halted = 1'b0;
    repeat (2) @(negedge clk);
    check("reset.outputs", 64'(observe()), 64'(obs_t'(0)));
    clr = 1'b1;
    @(negedge clk);
    check("reset.first_T0", 64'(observe()), 64'(obs_t'{s: FETCH0, alu: A_ADD, run: 1'b1, ill: 1'b0}));

    // Directed table: one strobe/alu check per record plus fetch-to-fetch length.
    foreach (vec[i]) begin
      cyc = 0;
      done = 1'b0;
      ir = vec[i].word;
      con_ff = vec[i].con;
      while (!done) begin
        if (cyc == vec[i].step)
          check(vec[i].name, 64'({observe().s, observe().alu}), 64'({vec[i].mask, vec[i].alu}));
        if (cyc == 3) ir = $urandom;
        @(negedge clk);
        cyc++;
        if (PCout && IncPC) done = 1'b1;
        else if (cyc > 12) done = 1'b1;
      end
      check({vec[i].name, ".cycles"}, 64'(cyc), 64'(vec[i].ncyc));
      if (cyc != vec[i].ncyc) do_reset();
    end

    // clr in the middle of add T4 clears everything in the same cycle.
    ir = 32'h18908000;
    repeat (4) @(negedge clk);
    check("add.T4.pre_clr", 64'(observe().s), 64'(GRC|RO|ZLI));
    clr = 1'b0;
    #1;
    check("clr.mid_add", 64'(observe()), 64'(obs_t'(0)));
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    check("clr.release_T0", 64'(observe()), 64'(obs_t'{s: FETCH0, alu: A_ADD, run: 1'b1, ill: 1'b0}));

    // clr during st T7 drops RAM_write at once.
    ir = 32'h10000000;
    repeat (7) @(negedge clk);
    check("st.T7.pre_clr", 64'(RAM_write), 64'(1));
    clr = 1'b0;
    #1;
    check("clr.st_T7", 64'(RAM_write), 64'(0));
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);

    // Undefined opcode runs as nop and sets the sticky flag until clr.
    run_model_instr("ill", 32'hF8000000, 1'b0, -1);
    check("ill.flag_T0", 64'({illegal, PCout, run}), 64'(3'b111));
    run_model_instr("nop_after_ill", 32'hD0000000, 1'b0, -1);
    check("ill.sticky", 64'(illegal), 64'(1));
    do_reset();
    check("ill.cleared", 64'(illegal), 64'(0));

    // stop raised only during add T4 still completes T5, then halts.
    run_model_instr("stop_add", 32'h18908000, 1'b0, 4);
    check_halted("stop_add", 4);
    do_reset();

    // halt opcode: fetch, then run=0 held regardless of ir.
    run_model_instr("halt", 32'hD8000000, 1'b0, -1);
    check_halted("halt", 5);
    do_reset();

    // Random instruction stream against the model.
    for (int i = 0; i < 300; i++) begin
      opc = 5'($urandom_range(0, 31));
      model_exec(opc, 1'b0);
      stop_idx = -1;
      if ($urandom_range(0, 9) == 0) stop_idx = $urandom_range(0, 2 + m_seq.size());
      run_model_instr($sformatf("rand%0d", i), {opc, 27'($urandom)}, 1'($urandom), stop_idx);
      if (m_halted) begin
        check_halted($sformatf("rand%0d", i), 2);
        do_reset();
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
